// File: rtl/fx_pkg.sv
// Shared definitions for the delay-line effects: sequencer states, capture
// targets and effect-enable bit positions.
package fx_pkg;

   localparam int ADDR_W_DEF = 14;
   localparam int DATA_W_DEF = 16;

   localparam int EN_CHOR = 0;
   localparam int EN_REV  = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_CHOR = 3'd1,
      ST_RD_REV  = 3'd2,
      ST_WR      = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CAP_NONE = 2'd0,
      CAP_CHOR = 2'd1,
      CAP_REV  = 2'd2
   } cap_t;

endpackage

// File: rtl/circ_ptr.sv
// Circular write pointer for a power-of-two delay line, with a combinational
// tap address (wp - delay) that wraps naturally.
module circ_ptr
   import fx_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              adv,
   input  logic [ADDR_W-1:0] dly,
   output logic [ADDR_W-1:0] wp,
   output logic [ADDR_W-1:0] tap_addr
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wp <= '0;
      else if (adv)
         wp <= wp + ADDR_W'(1);
   end

   assign tap_addr = wp - dly;

endmodule

// File: rtl/delay_tap_arbiter.sv
// Sequences the shared single-port delay RAM: up to two tap reads (chorus,
// reverb), then the write of the new sample, then one output strobe.
module delay_tap_arbiter
   import fx_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_in,
   input  logic [ADDR_W-1:0] chorus_dly,
   input  logic [ADDR_W-1:0] reverb_dly,
   input  logic [1:0]        effect_en,
   input  logic              ovr_clr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] main_out,
   output logic [DATA_W-1:0] chorus_out,
   output logic [DATA_W-1:0] reverb_out,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun
);

   state_t            state, state_nx;
   cap_t              cap_p1;
   logic [DATA_W-1:0] smp_p0, chor_p1;
   logic [ADDR_W-1:0] chor_dly_p0, rev_dly_p0;
   logic [1:0]        en_p0;
   logic [ADDR_W-1:0] wp, tap_addr, tap_dly;
   logic              accept;

   function automatic state_t first_state(input logic [1:0] en);
      if (en[EN_CHOR])
         return ST_RD_CHOR;
      else if (en[EN_REV])
         return ST_RD_REV;
      else
         return ST_WR;
   endfunction

   assign busy      = (state != ST_IDLE) && (state != ST_DONE);
   assign accept    = sample_valid && !busy;
   assign out_valid = (state == ST_DONE);
   assign tap_dly   = (state == ST_RD_REV) ? rev_dly_p0 : chor_dly_p0;

   circ_ptr #(.ADDR_W(ADDR_W)) u_ptr (
      .clk      (clk),
      .reset    (reset),
      .adv      (state == ST_DONE),
      .dly      (tap_dly),
      .wp       (wp),
      .tap_addr (tap_addr)
   );

   always_comb begin
      state_nx  = state;
      mem_addr  = wp;
      mem_we    = 1'b0;
      mem_wdata = '0;
      unique case (state)
         ST_IDLE:    if (accept) state_nx = first_state(effect_en);
         ST_RD_CHOR: begin
            mem_addr = tap_addr;
            state_nx = en_p0[EN_REV] ? ST_RD_REV : ST_WR;
         end
         ST_RD_REV: begin
            mem_addr = tap_addr;
            state_nx = ST_WR;
         end
         ST_WR: begin
            mem_we    = 1'b1;
            mem_wdata = smp_p0;
            state_nx  = ST_DONE;
         end
         ST_DONE:    state_nx = accept ? first_state(effect_en) : ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Stage p0: request latched at acceptance; p1: read data one cycle after its address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cap_p1     <= CAP_NONE;
         overrun    <= 1'b0;
         main_out   <= '0;
         chorus_out <= '0;
         reverb_out <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_RD_CHOR)
            cap_p1 <= CAP_CHOR;
         else if (state == ST_RD_REV)
            cap_p1 <= CAP_REV;
         else
            cap_p1 <= CAP_NONE;
         if (sample_valid && busy)
            overrun <= 1'b1;
         else if (ovr_clr)
            overrun <= 1'b0;
         // Chorus data is either arriving now (no reverb read) or was parked in chor_p1
         if (state == ST_WR) begin
            main_out   <= smp_p0;
            chorus_out <= !en_p0[EN_CHOR] ? '0 :
                          (cap_p1 == CAP_CHOR) ? mem_rdata : chor_p1;
            reverb_out <= (cap_p1 == CAP_REV) ? mem_rdata : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         smp_p0      <= sample_in;
         chor_dly_p0 <= chorus_dly;
         rev_dly_p0  <= reverb_dly;
         en_p0       <= effect_en;
      end
      if (cap_p1 == CAP_CHOR)
         chor_p1 <= mem_rdata;
   end

endmodule

// File: tb/tb_delay_tap_arbiter.sv
// Bench for delay_tap_arbiter: a 1-cycle-latency RAM model plus a sample
// history that predicts every RAM access and tap value.
module tb_delay_tap_arbiter;

   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0, reset = 1'b1, sample_valid = 1'b0, ovr_clr = 1'b0, ram_clr = 1'b0;
   logic [DW-1:0] sample_in = '0;
   logic [AW-1:0] chorus_dly = '0, reverb_dly = '0;
   logic [1:0]    effect_en = '0;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, main_out, chorus_out, reverb_out;
   logic          mem_we, out_valid, busy, overrun;

   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] hist [$];
   logic [AW-1:0] acc_addr [8];
   logic          acc_we [8];
   int            we_cnt = 0;
   int            total = 0, bad = 0, we0 = 0;

   delay_tap_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .chorus_dly   (chorus_dly),
      .reverb_dly   (reverb_dly),
      .effect_en    (effect_en),
      .ovr_clr      (ovr_clr),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_rdata    (mem_rdata),
      .main_out     (main_out),
      .chorus_out   (chorus_out),
      .reverb_out   (reverb_out),
      .out_valid    (out_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      end else begin
         if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
         end
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Sample written d periods ago; d == 0 means a full trip round the line.
   function automatic logic [DW-1:0] tap_ref(input int d);
      int dd;
      int idx;
      dd  = (d == 0) ? DEPTH : d;
      idx = hist.size() - dd;
      return (idx < 0) ? '0 : hist[idx];
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ram_clr = 1'b1;
      sample_valid = 1'b0;
      ovr_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_main", 32'(main_out), 32'(0));
      chk("rst_chorus", 32'(chorus_out), 32'(0));
      chk("rst_reverb", 32'(reverb_out), 32'(0));
      chk("rst_valid", 32'(out_valid), 32'(0));
      chk("rst_we", 32'(mem_we), 32'(0));
      chk("rst_addr", 32'(mem_addr), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_ovr", 32'(overrun), 32'(0));
      ram_clr = 1'b0;
      reset = 1'b0;
      hist.delete();
   endtask

   // Called at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle.
   task automatic do_sample(input logic [DW-1:0] s, input logic [AW-1:0] cd,
                            input logic [AW-1:0] rd, input logic [1:0] en, input int inj);
      int            n, cyc, taps, k;
      logic [AW-1:0] ea [4];
      logic          ew [4];
      logic [DW-1:0] ec, er;
      n = hist.size();
      taps = 0;
      k = 0;
      if (en[0]) begin ea[k] = AW'(n - int'(cd)); ew[k] = 1'b0; k++; taps++; end
      if (en[1]) begin ea[k] = AW'(n - int'(rd)); ew[k] = 1'b0; k++; taps++; end
      ea[k] = AW'(n); ew[k] = 1'b1; k++;
      ec = en[0] ? tap_ref(int'(cd)) : '0;
      er = en[1] ? tap_ref(int'(rd)) : '0;
      sample_valid = 1'b1;
      sample_in = s;
      chorus_dly = cd;
      reverb_dly = rd;
      effect_en = en;
      @(negedge clk);
      sample_valid = 1'b0;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 12) begin
         if (inj > 0 && cyc == inj + 1) chk("ovr_set", 32'(overrun), 32'(1));
         sample_valid = (cyc == inj);
         sample_in = 16'hdead;
         if (cyc < 8) begin
            acc_addr[cyc] = mem_addr;
            acc_we[cyc] = mem_we;
         end
         @(negedge clk);
         cyc++;
      end
      sample_valid = 1'b0;
      chk("latency", 32'(cyc), 32'(2 + taps));
      if (cyc == 2 + taps) begin
         for (int i = 0; i < k; i++) begin
            chk("ram_addr", 32'(acc_addr[i+1]), 32'(ea[i]));
            chk("ram_we", 32'(acc_we[i+1]), 32'(ew[i]));
         end
      end
      chk("main", 32'(main_out), 32'(s));
      chk("chorus", 32'(chorus_out), 32'(ec));
      chk("reverb", 32'(reverb_out), 32'(er));
      chk("busy_done", 32'(busy), 32'(0));
      hist.push_back(s);
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // basic taps
      for (int v = 1; v <= 5; v++) begin
         do_sample(DW'(v), AW'(2), AW'(4), 2'b11, 0);
         if (v == 5) begin
            chk("basic_main", 32'(main_out), 32'h5);
            chk("basic_chor", 32'(chorus_out), 32'h3);
            chk("basic_rev", 32'(reverb_out), 32'h1);
         end
         idle(1);
         chk("valid_pulse", 32'(out_valid), 32'(0));
      end

      // wrap with zero chorus delay
      do_reset();
      for (int v = 1; v <= 20; v++) begin
         do_sample(DW'(v), AW'(0), AW'(5), 2'b11, 0);
         if (v == 20) begin
            chk("wrap_rev_addr", 32'(acc_addr[2]), 32'd14);
            chk("wrap_rev", 32'(reverb_out), 32'd15);
            chk("wrap_chor", 32'(chorus_out), 32'd4);
         end
         idle(1);
      end

      // bypass and reverb-only
      we0 = we_cnt;
      do_sample(16'h0aa0, AW'(3), AW'(3), 2'b00, 0);
      chk("byp_writes", 32'(we_cnt - we0), 32'(1));
      chk("byp_chor", 32'(chorus_out), 32'(0));
      idle(1);
      do_sample(16'h0bb0, AW'(3), AW'(2), 2'b10, 0);
      chk("rev_only_chor", 32'(chorus_out), 32'(0));
      idle(1);

      // overrun during RD_REV
      do_sample(16'h1234, AW'(1), AW'(2), 2'b11, 2);
      idle(2);
      chk("ovr_sticky", 32'(overrun), 32'(1));
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'(0));
      do_sample(16'h5678, AW'(1), AW'(1), 2'b11, 0);

      // back-to-back acceptance in DONE
      do_sample(16'h9abc, AW'(2), AW'(3), 2'b11, 0);
      chk("b2b_ovr", 32'(overrun), 32'(0));
      idle(1);

      // randomized traffic
      repeat (60) begin
         idle(int'($urandom_range(0, 2)));
         do_sample(DW'($urandom), AW'($urandom), AW'($urandom), 2'($urandom), 0);
      end
      chk("rand_ovr", 32'(overrun), 32'(0));
      idle(1);

      // reset in RD_REV aborts the write
      we0 = we_cnt;
      sample_in = 16'h7777;
      chorus_dly = AW'(1);
      reverb_dly = AW'(2);
      effect_en = 2'b11;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      chk("midop_busy", 32'(busy), 32'(1));
      reset = 1'b1;
      #1;
      chk("midop_we", 32'(mem_we), 32'(0));
      repeat (3) begin
         @(negedge clk);
         chk("midop_valid", 32'(out_valid), 32'(0));
      end
      chk("midop_nowrite", 32'(we_cnt), 32'(we0));
      do_reset();
      do_sample(16'hbeef, AW'(1), AW'(2), 2'b11, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/delay_tap_arbiter.md
Name: delay_tap_arbiter

Overview:
- Sequences all accesses to the single-port delay-line RAM (SPRAM) shared by the chorus and reverb effects.
- Per accepted input sample it issues up to two tap reads (chorus, reverb), then writes the new sample at the circular write pointer.
- It then presents dry, chorus and reverb samples together with a one-cycle valid.
- Sits between the audio input path and the effect mixing / MCU SPI transfer sequencer.

Parameters:
- ADDR_W, 14, delay-line address width; depth = 2^ADDR_W words.
- DATA_W, 16, sample width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- sample_valid  in  1  one-cycle strobe: new input sample present
- sample_in  in  DATA_W  input sample, sampled with sample_valid
- chorus_dly  in  ADDR_W  chorus tap delay in samples, sampled with sample_valid
- reverb_dly  in  ADDR_W  reverb tap delay in samples, sampled with sample_valid
- effect_en  in  2  bit0 chorus tap enable, bit1 reverb tap enable; sampled with sample_valid
- ovr_clr  in  1  clears overrun flag
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM read data; valid 1 cycle after address (fixed latency 1)
- main_out  out  DATA_W  dry sample of the completed period
- chorus_out  out  DATA_W  chorus tap sample
- reverb_out  out  DATA_W  reverb tap sample
- out_valid  out  1  one-cycle pulse: outputs updated
- busy  out  1  high in every state except IDLE and DONE
- overrun  out  1  sticky: sample_valid arrived while busy

Behaviour:
- Reset values:
  - state IDLE; write pointer wp = 0.
  - All outputs 0; mem_we = 0.
  - Reset asserted mid-operation aborts immediately; no write is issued; pending samples are discarded.
- States: IDLE, RD_CHOR, RD_REV, WR, DONE.
- Accepting a sample:
  - Accepted when sample_valid is high in IDLE or DONE.
  - On acceptance, latch sample_in, both delays and effect_en.
  - Next state: RD_CHOR if en[0]; else RD_REV if en[1]; else WR.
- RD_CHOR:
  - mem_addr = (wp - chorus_dly) mod 2^ADDR_W; mem_we = 0.
  - Next state: RD_REV if en[1], else WR.
- RD_REV:
  - mem_addr = (wp - reverb_dly) mod 2^ADDR_W.
  - Next state: WR.
- WR:
  - mem_addr = wp, mem_wdata = latched sample, mem_we = 1.
  - Next state: DONE.
- Read-data capture:
  - mem_rdata is captured one cycle after each read address.
  - Chorus data is captured in the cycle following RD_CHOR (RD_REV or WR).
  - Reverb data is captured in WR.
  - Implement via a one-cycle-delayed capture-target register.
- DONE:
  - out_valid = 1 for exactly this cycle.
  - main_out, chorus_out and reverb_out update at entry to DONE and hold until the next DONE.
  - A disabled tap outputs 0.
  - wp increments (wraps 2^ADDR_W-1 → 0).
  - Next state: IDLE, or directly accept if sample_valid is high.
- Latency: sample_valid cycle → out_valid = 2 + (number of enabled taps) cycles (2, 3 or 4).
- Tap semantics:
  - Reads precede the write, so delay d returns the sample written d periods earlier.
  - d = 0 returns the sample written 2^ADDR_W periods earlier (full wrap).
- In IDLE/DONE: mem_addr = wp, mem_we = 0.
- Overrun:
  - sample_valid while busy sets overrun; that sample is dropped.
  - The in-flight sequence and wp are unaffected.
  - ovr_clr clears overrun. If ovr_clr and a new overrun occur in the same cycle, set wins.
- Arithmetic: unsigned ADDR_W-bit subtraction/increment, natural wrap; no saturation.

Decomposition:
- Shared package fx_pkg: state enum (3-bit), ADDR_W/DATA_W defaults, effect_en bit index constants.
- One sub-module: circ_ptr
  - Holds wp; increment on DONE.
  - Combinational tap address = wp - delay.
  - Reused by future delay-based effects.

Test Plan:
- Basic taps:
  - Stimulus: reset; ADDR_W=14; en=2'b11, chorus_dly=2, reverb_dly=4; write samples 0x0001..0x0005.
  - Response: on 5th out_valid, main_out=0x0005, chorus_out=0x0003, reverb_out=0x0001; out_valid 4 cycles after each sample_valid.
- Wrap:
  - Stimulus: ADDR_W=4, en=2'b11, chorus_dly=0, reverb_dly=5; samples 1..20.
  - Response: for sample 20, mem_addr=14 in RD_REV, reverb_out=15, chorus_out=4.
- Bypass:
  - Stimulus: en=2'b00.
  - Response: out_valid 2 cycles after sample_valid; chorus_out=reverb_out=0; only one RAM cycle, with mem_we=1 at wp.
  - Stimulus: en=2'b10.
  - Response: latency 3; chorus_out=0.
- Overrun:
  - Stimulus: sample_valid during RD_REV.
  - Response: overrun=1 next cycle; wp advances by 1 only; in-flight outputs unchanged; ovr_clr pulse → overrun=0.
- Back-to-back:
  - Stimulus: sample_valid in the DONE cycle.
  - Response: accepted, no overrun; next out_valid 4 cycles later.
- Reset mid-op:
  - Stimulus: reset asserted in RD_REV.
  - Response: mem_we never asserts, out_valid stays 0, wp=0; first post-reset sample written at addr 0.
